// File: rtl/computation_control_module.sv
// computation_control_module: sequences store and compute phases of computation_module, captures the 2x2 result with its signed max, and guards each phase with a watchdog.
module computation_control_module #(
  parameter int TIMEOUT = 64,
  parameter int CW = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic       done_store,
  input  logic       done_single,
  input  logic       done_sa3,
  input  logic       done_sa2,
  input  logic [7:0] c11,
  input  logic [7:0] c12,
  input  logic [7:0] c21,
  input  logic [7:0] c22,
  input  logic       out_ready,
  output logic       active_store,
  output logic       active_single,
  output logic       active_sa3,
  output logic       active_sa2,
  output logic       busy,
  output logic       out_valid,
  output logic [7:0] r11,
  output logic [7:0] r12,
  output logic [7:0] r21,
  output logic [7:0] r22,
  output logic [7:0] r_max,
  output logic       err_mode,
  output logic       err_timeout
);
  typedef enum logic [1:0] {IDLE, STORE, COMPUTE, OUT} state_t;
  state_t state, state_n;
  logic [1:0] mode_q, mode_n;
  logic [CW-1:0] cnt, cnt_n;
  logic err_mode_n, err_timeout_n, capture, eng_done, expired;
  logic signed [7:0] m_top, m_bot, m_all;
  assign eng_done = mode_q == 2'd0 ? done_single : mode_q == 2'd1 ? done_sa3 : done_sa2;
  assign expired = cnt == CW'(TIMEOUT - 1);
  assign m_top = $signed(c11) > $signed(c12) ? $signed(c11) : $signed(c12);
  assign m_bot = $signed(c21) > $signed(c22) ? $signed(c21) : $signed(c22);
  assign m_all = m_top > m_bot ? m_top : m_bot;
  always_comb begin
    state_n = state;
    mode_n = mode_q;
    cnt_n = cnt;
    err_mode_n = 1'b0;
    err_timeout_n = err_timeout;
    capture = 1'b0;
    case (state)
      IDLE: if (start) begin
        if (mode == 2'd3) err_mode_n = 1'b1;
        else begin
          mode_n = mode;
          err_timeout_n = 1'b0;
          cnt_n = '0;
          state_n = STORE;
        end
      end
      STORE: begin
        cnt_n = cnt + 1'b1;
        if (done_store) begin
          cnt_n = '0;
          state_n = COMPUTE;
        end else if (expired) begin
          err_timeout_n = 1'b1;
          state_n = IDLE;
        end
      end
      COMPUTE: begin
        cnt_n = cnt + 1'b1;
        if (eng_done) begin
          capture = 1'b1;
          state_n = OUT;
        end else if (expired) begin
          err_timeout_n = 1'b1;
          state_n = IDLE;
        end
      end
      default: if (out_ready) state_n = IDLE;
    endcase
  end
  // Phase enables are decoded from the next state so they switch on the same edge as the state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      mode_q <= 2'd0;
      cnt <= '0;
      active_store <= 1'b0;
      active_single <= 1'b0;
      active_sa3 <= 1'b0;
      active_sa2 <= 1'b0;
      busy <= 1'b0;
      out_valid <= 1'b0;
      r11 <= 8'd0;
      r12 <= 8'd0;
      r21 <= 8'd0;
      r22 <= 8'd0;
      r_max <= 8'd0;
      err_mode <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state <= state_n;
      mode_q <= mode_n;
      cnt <= cnt_n;
      active_store <= state_n == STORE;
      active_single <= state_n == COMPUTE && mode_n == 2'd0;
      active_sa3 <= state_n == COMPUTE && mode_n == 2'd1;
      active_sa2 <= state_n == COMPUTE && mode_n == 2'd2;
      busy <= state_n != IDLE;
      out_valid <= state_n == OUT;
      err_mode <= err_mode_n;
      err_timeout <= err_timeout_n;
      if (capture) begin
        r11 <= c11;
        r12 <= c12;
        r21 <= c21;
        r22 <= c22;
        r_max <= m_all;
      end
    end
  end
endmodule

// File: tb/tb_computation_control_module.sv
// tb_computation_control_module: directed jobs with a result scoreboard checked by a forked monitor.
module tb_computation_control_module;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, out_ready = 1'b0;
  logic [1:0] mode = 2'd0;
  logic done_store = 1'b0, done_single = 1'b0, done_sa3 = 1'b0, done_sa2 = 1'b0;
  logic [7:0] c11 = 8'd0, c12 = 8'd0, c21 = 8'd0, c22 = 8'd0;
  logic active_store, active_single, active_sa3, active_sa2, busy, out_valid, err_mode, err_timeout;
  logic [7:0] r11, r12, r21, r22, r_max;
  logic [3:0] act;
  logic [31:0] rr;
  logic [39:0] sb[$];
  int cmp = 0, bad = 0;

  computation_control_module #(.TIMEOUT(8), .CW(16)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .done_store(done_store), .done_single(done_single), .done_sa3(done_sa3), .done_sa2(done_sa2),
    .c11(c11), .c12(c12), .c21(c21), .c22(c22), .out_ready(out_ready),
    .active_store(active_store), .active_single(active_single), .active_sa3(active_sa3), .active_sa2(active_sa2),
    .busy(busy), .out_valid(out_valid), .r11(r11), .r12(r12), .r21(r21), .r22(r22), .r_max(r_max),
    .err_mode(err_mode), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;
  assign act = {active_store, active_single, active_sa3, active_sa2};
  assign rr = {r11, r12, r21, r22};

  task automatic chk(input string name, input logic [39:0] got, input logic [39:0] exp);
    cmp++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_act"}, 40'(act), 40'd0);
    chk({name, "_flags"}, 40'({busy, out_valid, err_mode, err_timeout}), 40'd0);
    chk({name, "_r"}, {rr, r_max}, 40'd0);
  endtask

  // Pops one expectation per valid period; while valid stays high the held result must not move.
  task automatic monitor();
    bit seen = 0;
    logic [39:0] held = '0;
    forever begin
      @(negedge clk);
      if (!out_valid) seen = 0;
      else if (!seen) begin
        seen = 1;
        if (sb.size() == 0) chk("unexpected_valid", {rr, r_max}, 40'hx);
        else begin
          held = sb.pop_front();
          chk("result", {rr, r_max}, held);
        end
      end else chk("result_hold", {rr, r_max}, held);
    end
  endtask

  task automatic run_job(input logic [1:0] m, input int ds, input int dc, input logic [31:0] c,
                         input logic [7:0] mx, input int rd, input bit stray, input bit poke, input bit rst_out);
    logic [3:0] exp;
    exp = m == 2'd0 ? 4'b0100 : m == 2'd1 ? 4'b0010 : 4'b0001;
    start = 1; mode = m; tick(); start = 0;
    chk("accept_act", 40'(act), 40'b1000);
    chk("accept_busy", 40'(busy), 40'd1);
    if (poke) begin start = 1; mode = 2'd2; end
    repeat (ds) tick();
    start = 0; done_store = 1; tick(); done_store = 0;
    chk("route", 40'(act), 40'(exp));
    {c11, c12, c21, c22} = c;
    sb.push_back({c, mx});
    if (stray) done_single = 1;
    repeat (dc) tick();
    done_single = 0;
    chk("compute_act", 40'(act), 40'(exp));
    case (m)
      2'd0: done_single = 1;
      2'd1: done_sa3 = 1;
      default: done_sa2 = 1;
    endcase
    tick();
    {done_single, done_sa3, done_sa2} = 3'b0;
    chk("done_valid", 40'(out_valid), 40'd1);
    chk("done_act", 40'(act), 40'd0);
    {c11, c12, c21, c22} = ~c;
    if (rst_out) begin
      rst = 0; tick(); rst = 1;
      chk_zero("rst_out");
    end else begin
      repeat (rd) tick();
      chk("hold_valid", 40'(out_valid), 40'd1);
      out_ready = 1; tick(); out_ready = 0;
      chk("release", 40'({out_valid, busy}), 40'd0);
    end
  endtask

  initial begin
    fork monitor(); join_none
    tick(); tick();
    chk_zero("reset");
    rst = 1; tick();
    chk_zero("post_reset");
    run_job(2'd0, 3, 5, 32'h05FB_7F80, 8'h7F, 4, 0, 0, 0);
    run_job(2'd1, 1, 2, 32'h1020_E030, 8'h30, 1, 0, 0, 0);
    run_job(2'd2, 2, 3, 32'hF0FE_81C0, 8'hFE, 0, 1, 0, 0);
    run_job(2'd0, 0, 0, 32'h8081_8283, 8'h83, 0, 0, 0, 0);
    run_job(2'd0, 2, 1, 32'h0102_0304, 8'h04, 1, 0, 1, 0);
    start = 1; mode = 2'd3; tick(); start = 0;
    chk("err_mode_pulse", 40'({err_mode, busy}), 40'b10);
    tick();
    chk("err_mode_clear", 40'(err_mode), 40'd0);
    start = 1; mode = 2'd0; tick(); start = 0;
    for (int i = 0; i < 8; i++) begin
      chk("store_window", 40'(active_store), 40'd1);
      tick();
    end
    chk("store_timeout", 40'({act, busy, err_timeout}), 40'b000001);
    tick();
    chk("timeout_sticky", 40'(err_timeout), 40'd1);
    start = 1; tick(); start = 0;
    chk("timeout_cleared", 40'({err_timeout, busy}), 40'b01);
    done_store = 1; tick(); done_store = 0;
    repeat (7) tick();
    chk("compute_window", 40'(active_single), 40'd1);
    tick();
    chk("compute_timeout", 40'({act, busy, err_timeout}), 40'b000001);
    run_job(2'd1, 7, 7, 32'h7F00_FF01, 8'h7F, 0, 0, 0, 0);
    chk("edge_done_no_err", 40'(err_timeout), 40'd0);
    start = 1; mode = 2'd2; tick(); start = 0;
    done_store = 1; tick(); done_store = 0;
    rst = 0; tick(); rst = 1;
    chk_zero("rst_compute");
    run_job(2'd2, 1, 1, 32'h2233_4455, 8'h55, 0, 0, 0, 1);
    run_job(2'd1, 1, 1, 32'hFFFE_FDFC, 8'hFF, 2, 0, 0, 0);
    tick();
    chk("sb_empty", 40'(sb.size()), 40'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule

// File: doc/computation_control_module.md
# computation_control_module

Sequencer that sits directly upstream of `computation_module` and also consumes its results. One `start` request runs a full job: a store phase (`active_store` until `done_store`), then a compute phase on the engine chosen by `mode` (single, 3×3 systolic or 2×2 systolic, until that engine's done). It then captures the 2×2 result `c11..c22`, computes its signed maximum, and holds the result for the downstream consumer under a valid/ready handshake. A per-phase watchdog returns the block to idle if the engine never finishes.

## Interface
Parameters:
- `TIMEOUT`, 64: maximum cycles per phase (store or compute) before abort; legal range 2..65535.
- `CW`, 16: width of the internal phase cycle counter; must hold `TIMEOUT`.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `start`  in  1  job request; sampled only in IDLE.
- `mode`  in  2  engine select, sampled with `start`: 0 = single, 1 = sa3, 2 = sa2, 3 = illegal.
- `done_store`, `done_single`, `done_sa3`, `done_sa2`  in  1 each  completion flags from `computation_module`.
- `c11`, `c12`, `c21`, `c22`  in  8 each  result bus from `computation_module`.
- `out_ready`  in  1  downstream accepts the result.
- `active_store`, `active_single`, `active_sa3`, `active_sa2`  out  1 each  phase enables to `computation_module`; registered, at most one high.
- `busy`  out  1  high in any state other than IDLE.
- `out_valid`  out  1  result registers are valid.
- `r11`, `r12`, `r21`, `r22`  out  8 each  captured result.
- `r_max`  out  8  signed maximum of `r11..r22`.
- `err_mode`  out  1  one-cycle pulse when `start` arrives with `mode` = 3.
- `err_timeout`  out  1  sticky abort flag; cleared by reset or by the next accepted `start`.

## Operation
- States: IDLE, STORE, COMPUTE, OUT. Mode is latched into `mode_q` when a job is accepted.
- **IDLE**
  - `start` with `mode` ≠ 3: latch mode, clear `err_timeout`, clear counter, go to STORE.
  - `start` with `mode` = 3: pulse `err_mode`, stay in IDLE.
- **STORE**
  - `active_store` = 1.
  - `done_store` = 1: clear counter, go to COMPUTE.
- **COMPUTE**
  - The `active_*` selected by `mode_q` = 1.
  - Matching done = 1: capture `c11..c22` into `r11..r22` on that same edge (the active level is still high, so the engine's output mux is valid), compute `r_max`, go to OUT.
- **OUT**
  - `out_valid` = 1; `r*` and `r_max` are held stable.
  - `out_ready` = 1: drop `out_valid`, go to IDLE. Results stay readable but are no longer valid.
- **Watchdog**, in STORE and COMPUTE:
  - The counter increments every cycle in the phase.
  - When the counter equals `TIMEOUT-1` and no done is present: set `err_timeout`, drop all `active_*`, go to IDLE.
  - Done and timeout on the same cycle: done wins.
- Done flags are ignored in any state they do not match: `done_sa2` in a single job, `done_store` in COMPUTE, anything in IDLE/OUT.
- `start` is ignored while `busy`.
- `r_max` arithmetic:
  - Operands are 8-bit two's complement; comparisons are signed (8'h80 < 8'h7F).
  - Ties are irrelevant because the output is a value.
  - Registered alongside `r*`.

## Timing
- Reset values (`rst` = 0 at an edge, effective on that edge, any state including mid-job):
  - state IDLE; counter 0.
  - all `active_*` = 0; `busy` = 0; `out_valid` = 0.
  - `r*` = 0, `r_max` = 0.
  - `err_mode` = 0, `err_timeout` = 0.
- All outputs are registered; there are no combinational input-to-output paths.
- `start` accepted at edge N: `active_store` and `busy` high from N+1.
- `done_store` high at edge M: `active_store` low and the compute `active_*` high from M+1. Exactly one overlap-free handoff.
- Engine done high at edge K: `r*` and `r_max` valid and `out_valid` high from K+1; compute `active_*` low from K+1.
- `out_ready` high at edge J while `out_valid`: `out_valid` and `busy` low from J+1. A new `start` is accepted from J+1 at the earliest.
- Minimum job with done returned on the first active cycle: `start` edge N, `out_valid` at N+3.
- Timeout: a phase with no done aborts after exactly `TIMEOUT` active cycles. `err_timeout` rises and `busy` falls on the same edge.
- `err_mode` is high for exactly the cycle after the offending edge.

## Test plan
- **Reset values:** hold `rst` = 0 for 2 cycles, release → all outputs 0, state IDLE.
- **Single job:** `mode` = 0, `start` pulse; done_store 3 cycles later; done_single 5 cycles later with `c` = {8'h05, 8'hFB, 8'h7F, 8'h80} → `r*` match, `r_max` = 8'h7F, `out_valid` at done+1; `out_ready` held low 4 cycles keeps `r*` stable.
- **Per-mode routing:** repeat the job for `mode` = 1 and `mode` = 2 → only `active_sa3` / `active_sa2` assert. Stray `done_single` during an sa2 job is ignored. All-negative `c` = {8'hF0, 8'hFE, 8'h81, 8'hC0} → `r_max` = 8'hFE.
- **Illegal mode and busy start:** `start` with `mode` = 3 → `err_mode` pulses 1 cycle, `busy` stays 0. `start` mid-job → ignored.
- **Timeout:** `TIMEOUT` = 8, `done_store` never asserted → `active_store` high exactly 8 cycles, then `err_timeout` = 1 and `busy` = 0. Next valid `start` clears `err_timeout`. Done on the timeout cycle → job proceeds.
- **Reset mid-operation:** drive `rst` = 0 during COMPUTE and during OUT → next edge all `active_*`, `out_valid` and `r*` are 0. Afterwards a fresh job completes normally.
